// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: two-requester load/run/done sequencer for an external counter (COUNTER_SEQ_RR_EN selects round-robin tie-break)
module counter_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int RUN_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] val0,
  input  logic [WIDTH-1:0] val1,
  input  logic [RUN_W-1:0] len0,
  input  logic [RUN_W-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             l,
  output logic             s_s,
  output logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             owner
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t           state_q;
  logic [RUN_W-1:0] cnt_q;
  logic [WIDTH-1:0] d_q, result_q;
  logic             gnt0_q, gnt1_q, l_q, s_s_q, done_q, busy_q, owner_q;
  logic             win_d;
`ifdef COUNTER_SEQ_RR_EN
  logic             last_q;
  // tie goes to the requester not granted last; last_q resets to 1 so req0 wins first
  always_comb win_d = (req0 && req1) ? ~last_q : ~req0;
`else
  // fixed priority: req0 always wins
  always_comb win_d = ~req0;
`endif
  // sequencer FSM with every output registered
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      d_q      <= '0;
      result_q <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      l_q      <= 1'b0;
      s_s_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      owner_q  <= 1'b0;
`ifdef COUNTER_SEQ_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      l_q    <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (req0 || req1) begin
          state_q <= LOAD;
          busy_q  <= 1'b1;
          l_q     <= 1'b1;
          owner_q <= win_d;
          gnt0_q  <= ~win_d;
          gnt1_q  <= win_d;
          d_q     <= win_d ? val1 : val0;
          cnt_q   <= win_d ? len1 : len0;
`ifdef COUNTER_SEQ_RR_EN
          last_q  <= win_d;
`endif
        end
        LOAD: begin
          state_q <= (|cnt_q) ? RUN : DONE;
          s_s_q   <= |cnt_q;
          done_q  <= ~|cnt_q;
        end
        RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == RUN_W'(1)) begin
            state_q <= DONE;
            s_s_q   <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          result_q <= c;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign l      = l_q;
  assign s_s    = s_s_q;
  assign d      = d_q;
  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign owner  = owner_q;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: scoreboard bench for counter_seq_ctrl with an attached up-counter
`timescale 1ns/1ps
module tb_counter_seq_ctrl;
`ifdef COUNTER_SEQ_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic       clk = 1'b0, clr = 1'b1, req0 = 1'b0, req1 = 1'b0;
  logic [7:0] val0 = '0, val1 = '0, len0 = '0, len1 = '0, c = '0;
  logic [7:0] d, result;
  logic       gnt0, gnt1, l, s_s, done, busy, owner;
  int         total = 0, bad = 0;
  typedef struct {bit o; logic [7:0] v; int n; logic [7:0] r;} exp_t;
  exp_t       q[$];
  exp_t       cur;
  bit         act = 1'b0, res_pend = 1'b0;
  int         runs = 0;
  bit         p0 = 1'b0, p1 = 1'b0, last_w = 1'b1;
  logic [7:0] pv0 = '0, pl0 = '0, pv1 = '0, pl1 = '0;

  always #5 clk = ~clk;

  counter_seq_ctrl dut (
    .clk(clk), .clr(clr), .req0(req0), .req1(req1), .val0(val0), .val1(val1),
    .len0(len0), .len1(len1), .gnt0(gnt0), .gnt1(gnt1), .l(l), .s_s(s_s),
    .d(d), .c(c), .result(result), .done(done), .busy(busy), .owner(owner)
  );

  // external up-counter driven by the sequencer
  always @(posedge clk or negedge clr)
    if (!clr) c <= '0;
    else if (l) c <= d;
    else if (s_s) c <= c + 8'd1;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  // monitor: pops an expected command on each grant and follows it to done/result
  always @(negedge clk) begin
    if (!clr) begin
      act = 1'b0;
      res_pend = 1'b0;
    end else begin
      if (gnt0 && gnt1) chk("gnt_exclusive", 1, 0);
      if (l && s_s) chk("l_ss_exclusive", 1, 0);
      if (res_pend) begin
        chk("result", result, cur.r);
        chk("busy_after", busy, 0);
        res_pend = 1'b0;
      end
      if (gnt0 || gnt1) begin
        if (act) chk("gnt_in_run", 1, 0);
        if (q.size() == 0) chk("gnt_unexpected", 1, 0);
        else begin
          cur = q.pop_front();
          act = 1'b1;
          runs = 0;
          chk("gnt_idx", gnt1, cur.o);
          chk("owner", owner, cur.o);
          chk("d_load", d, cur.v);
          chk("l_load", l, 1);
          chk("ss_load", s_s, 0);
          chk("busy_load", busy, 1);
        end
      end else if (act) begin
        if (s_s) begin
          runs++;
          chk("d_run", d, cur.v);
        end
        if (done) begin
          chk("run_len", runs, cur.n);
          chk("ss_done", s_s, 0);
          chk("d_done", d, cur.v);
          chk("owner_done", owner, cur.o);
          act = 1'b0;
          res_pend = 1'b1;
        end
      end else if (done || s_s || l) chk("unexpected_activity", {done, s_s, l}, 0);
    end
  end

  task automatic raise(bit i, logic [7:0] v, logic [7:0] n);
    if (i) begin p1 = 1'b1; pv1 = v; pl1 = n; req1 = 1'b1; val1 = v; len1 = n; end
    else   begin p0 = 1'b1; pv0 = v; pl0 = n; req0 = 1'b1; val0 = v; len0 = n; end
  endtask

  // reference: winner from pending set and tie rule, result = load value + run length
  task automatic run_cmd();
    exp_t e;
    bit   w;
    int   k;
    w = (p0 && p1) ? (RR ? !last_w : 1'b0) : !p0;
    e.o = w;
    e.v = w ? pv1 : pv0;
    e.n = int'(w ? pl1 : pl0);
    e.r = 8'(int'(e.v) + e.n);
    q.push_back(e);
    last_w = w;
    k = 0;
    do begin @(negedge clk); k++; end while (!(gnt0 || gnt1) && k < 4);
    if (!(gnt0 || gnt1)) begin chk("gnt_timeout", 1, 0); return; end
    if (w) begin p1 = 1'b0; req1 = 1'b0; end else begin p0 = 1'b0; req0 = 1'b0; end
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (s_s) begin
        if (!p1) req1 = 1'($urandom);
        if (!p0) begin val0 = 8'($urandom); len0 = 8'($urandom); end
      end
    end while (!done && k < e.n + 8);
    if (!done) chk("done_timeout", 1, 0);
    req0 = p0;
    req1 = p1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 clr = 1'b0;
    #1;
    chk("rst_l", l, 0); chk("rst_ss", s_s, 0); chk("rst_d", d, 0);
    chk("rst_gnt", {gnt0, gnt1}, 0); chk("rst_done", done, 0); chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0); chk("rst_result", result, 0);
    @(negedge clk); #2 clr = 1'b1;
    raise(1'b0, 8'h0E, 8'd5); run_cmd();
    raise(1'b1, 8'hE0, 8'd0); run_cmd();
    raise(1'b0, 8'($urandom), 8'd3); raise(1'b1, 8'($urandom), 8'd3);
    repeat (4) begin
      run_cmd();
      if (!p0) raise(1'b0, 8'($urandom), 8'd3);
      else if (!p1) raise(1'b1, 8'($urandom), 8'd3);
    end
    while (p0 || p1) run_cmd();
    raise(1'b0, 8'hFE, 8'hFF); run_cmd();
    repeat (40) begin
      for (int i = 0; i < 2; i++)
        if (!(i ? p1 : p0) && $urandom_range(1, 0) == 1)
          raise(1'(i), 8'($urandom), ($urandom_range(7, 0) == 0) ? 8'($urandom) : 8'($urandom_range(11, 0)));
      if (!p0 && !p1) raise(1'($urandom), 8'($urandom), 8'($urandom_range(9, 0)));
      run_cmd();
    end
    while (p0 || p1) run_cmd();
    // abort a len=10 command in its third run cycle
    raise(1'b0, 8'h33, 8'd10);
    q.push_back('{1'b0, 8'h33, 10, 8'h3D});
    last_w = 1'b0;
    begin
      int k;
      k = 0;
      do begin @(negedge clk); k++; end while (!gnt0 && k < 4);
      chk("abort_gnt", gnt0, 1);
      p0 = 1'b0; req0 = 1'b0;
      k = 0;
      do begin @(negedge clk); k++; end while (!s_s && k < 4);
      repeat (2) @(negedge clk);
    end
    chk("abort_pre_ss", s_s, 1);
    #2 clr = 1'b0;
    #1;
    chk("abort_ss", s_s, 0); chk("abort_busy", busy, 0); chk("abort_d", d, 0);
    chk("abort_done", done, 0); chk("abort_l", l, 0); chk("abort_result", result, 0);
    chk("abort_owner", owner, 0);
    q.delete();
    last_w = 1'b1;
    raise(1'b1, 8'h5A, 8'd2); raise(1'b0, 8'hA5, 8'd1);
    repeat (2) @(negedge clk);
    #2 clr = 1'b1;
    while (p0 || p1) run_cmd();
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
